// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive path.
// Line symbols are encoded as {dp, dm}.
package usb_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_DATA,
      ST_EOP,
      ST_ERR
   } rx_state_e;

   localparam logic [1:0] LINE_J   = 2'b10;
   localparam logic [1:0] LINE_K   = 2'b01;
   localparam logic [1:0] LINE_SE0 = 2'b00;

   localparam int STUFF_LEN      = 6;
   localparam int SYNC_MIN_ZEROS = 5;

   localparam logic [15:0] CRC16_POLY     = 16'h8005;
   localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
   localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

   localparam logic [7:0] PID_DATA0 = 8'hC3;
   localparam logic [7:0] PID_DATA1 = 8'h4B;

   // SE1 is not a legal bus state; it is folded into SE0.
   function automatic logic line_is_se0(input logic [1:0] line);
      return line[1] == line[0];
   endfunction

endpackage

// File: rtl/usb_crc16_chk.sv
// Serial CRC16 LFSR (x^16+x^15+x^2+1) fed one data bit per enable, with synchronous clear.
// Only built into the receiver when USB_RX_CRC16_EN is defined.
module usb_crc16_chk
   import usb_rx_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic        bit_i,
   output logic [15:0] crc_o
);

   logic [15:0] crc_q;
   logic [15:0] crc_d;
   logic        fb;

   assign fb    = crc_q[15] ^ bit_i;
   assign crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
   assign crc_o = crc_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         crc_q <= CRC16_INIT;
      end else if (clr_i) begin
         crc_q <= CRC16_INIT;
      end else if (en_i) begin
         crc_q <= crc_d;
      end
   end

endmodule

// File: rtl/usb_nrzi_rx.sv
// USB full-speed receive front end: NRZI decode, bit unstuffing, SYNC/EOP framing, byte assembly.
// Defining USB_RX_CRC16_EN adds CRC16 residual checking of DATA0/DATA1 packets.
module usb_nrzi_rx
   import usb_rx_pkg::*;
#(
   parameter int MAX_BYTES    = 67,
   parameter int SE0_MAX_BITS = 3
) (
   input  logic       useClk,
   input  logic       resetN,
   input  logic       bitEn,
   input  logic       dp,
   input  logic       dm,
   output logic [7:0] rxData,
   output logic       rxValid,
   output logic       rxActive,
   output logic       packetDone,
   output logic       rxError,
   output logic       busReset,
   output logic       crcOk
);

   localparam int BC_W = $clog2(MAX_BYTES + 2);
   localparam int S0_W = $clog2(SE0_MAX_BITS + 2);
   localparam logic [BC_W-1:0] BYTES_MAX = BC_W'(MAX_BYTES);
   localparam logic [S0_W-1:0] SE0_MAX   = S0_W'(SE0_MAX_BITS);
   localparam logic [2:0]      STUFF_CNT = 3'(STUFF_LEN);
   localparam logic [2:0]      SYNC_CNT  = 3'(SYNC_MIN_ZEROS);

   rx_state_e       state_q;
   logic [1:0]      prev_line_q;
   logic [2:0]      zero_cnt_q;
   logic [2:0]      ones_cnt_q;
   logic [2:0]      bit_cnt_q;
   logic [BC_W-1:0] byte_cnt_q;
   logic [S0_W-1:0] se0_cnt_q;
   logic [S0_W-1:0] se0_cnt_d;
   logic [7:0]      shift_q;
   logic [7:0]      rx_data_q;
   logic            rx_valid_q;
   logic            rx_active_q;
   logic            packet_done_q;
   logic            rx_error_q;
   logic            bus_reset_q;

   logic [1:0] line;
   logic       line_se0;
   logic       line_j;
   logic       line_k;
   logic       nrzi_bit;
   logic       stuff_bit;
   logic       se0_long;
   logic       eop_ok;
   logic [7:0] shift_d;

   assign line      = {dp, dm};
   assign line_se0  = line_is_se0(line);
   assign line_j    = (line == LINE_J);
   assign line_k    = (line == LINE_K);
   assign nrzi_bit  = (line == prev_line_q);
   assign shift_d   = {nrzi_bit, shift_q[7:1]};
   assign stuff_bit = (ones_cnt_q == STUFF_CNT);
   assign eop_ok    = line_j && (se0_cnt_q <= SE0_MAX);

   // SE0 run length saturates one past the EOP limit, which is all busReset needs.
   always_comb begin
      se0_cnt_d = '0;
      if (line_se0) begin
         se0_cnt_d = (se0_cnt_q > SE0_MAX) ? se0_cnt_q : se0_cnt_q + S0_W'(1);
      end
   end

   assign se0_long = (se0_cnt_d > SE0_MAX);

   always_ff @(posedge useClk or negedge resetN) begin
      if (!resetN) begin
         state_q       <= ST_IDLE;
         prev_line_q   <= LINE_J;
         zero_cnt_q    <= '0;
         ones_cnt_q    <= '0;
         bit_cnt_q     <= '0;
         byte_cnt_q    <= '0;
         se0_cnt_q     <= '0;
         shift_q       <= '0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         rx_active_q   <= 1'b0;
         packet_done_q <= 1'b0;
         rx_error_q    <= 1'b0;
         bus_reset_q   <= 1'b0;
      end else begin
         rx_valid_q    <= 1'b0;
         packet_done_q <= 1'b0;
         if (bitEn) begin
            se0_cnt_q   <= se0_cnt_d;
            bus_reset_q <= se0_long;
            // The line idles at J after SE0, so that is the reference for the next decoded bit.
            prev_line_q <= line_se0 ? LINE_J : line;
            case (state_q)
               ST_IDLE: begin
                  if (line_k) begin
                     state_q    <= ST_SYNC;
                     zero_cnt_q <= 3'd1;
                  end
               end
               ST_SYNC: begin
                  if (line_se0) begin
                     state_q <= ST_IDLE;
                  end else if (!nrzi_bit) begin
                     if (zero_cnt_q < SYNC_CNT) zero_cnt_q <= zero_cnt_q + 3'd1;
                  end else if (zero_cnt_q >= SYNC_CNT) begin
                     state_q     <= ST_DATA;
                     rx_active_q <= 1'b1;
                     rx_error_q  <= 1'b0;
                     ones_cnt_q  <= '0;
                     bit_cnt_q   <= '0;
                     byte_cnt_q  <= '0;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
               ST_DATA: begin
                  if (line_se0) begin
                     state_q <= ST_EOP;
                  end else if (stuff_bit) begin
                     if (nrzi_bit) begin
                        rx_error_q <= 1'b1;
                        state_q    <= ST_ERR;
                     end else begin
                        ones_cnt_q <= '0;
                     end
                  end else begin
                     ones_cnt_q <= nrzi_bit ? ones_cnt_q + 3'd1 : 3'd0;
                     shift_q    <= shift_d;
                     bit_cnt_q  <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7) begin
                        if (byte_cnt_q == BYTES_MAX) begin
                           rx_error_q <= 1'b1;
                           state_q    <= ST_ERR;
                        end else begin
                           rx_data_q  <= shift_d;
                           rx_valid_q <= 1'b1;
                           byte_cnt_q <= byte_cnt_q + BC_W'(1);
                        end
                     end
                  end
               end
               ST_EOP: begin
                  if (line_se0) begin
                     if (se0_long) rx_error_q <= 1'b1;
                  end else begin
                     state_q     <= ST_IDLE;
                     rx_active_q <= 1'b0;
                     if (eop_ok) begin
                        packet_done_q <= 1'b1;
                        if (bit_cnt_q != 3'd0) rx_error_q <= 1'b1;
                     end else if (se0_cnt_q <= SE0_MAX) begin
                        rx_error_q <= 1'b1;
                     end
                  end
               end
               ST_ERR: begin
                  if (line_se0) state_q <= ST_EOP;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign rxData     = rx_data_q;
   assign rxValid    = rx_valid_q;
   assign rxActive   = rx_active_q;
   assign packetDone = packet_done_q;
   assign rxError    = rx_error_q;
   assign busReset   = bus_reset_q;

`ifdef USB_RX_CRC16_EN
   logic [7:0]  pid_q;
   logic        crc_ok_q;
   logic        crc_clr;
   logic        crc_en;
   logic [15:0] crc_val;

   // Everything after the PID, CRC field included, runs through the LFSR.
   assign crc_clr = (state_q == ST_IDLE);
   assign crc_en  = bitEn && (state_q == ST_DATA) && !line_se0 && !stuff_bit &&
                    (byte_cnt_q != '0);

   usb_crc16_chk u_crc (
      .clk_i  (useClk),
      .rst_ni (resetN),
      .clr_i  (crc_clr),
      .en_i   (crc_en),
      .bit_i  (nrzi_bit),
      .crc_o  (crc_val)
   );

   always_ff @(posedge useClk or negedge resetN) begin
      if (!resetN) begin
         pid_q    <= '0;
         crc_ok_q <= 1'b1;
      end else if (state_q == ST_IDLE) begin
         pid_q <= '0;
      end else if (bitEn) begin
         if ((state_q == ST_DATA) && !line_se0 && !stuff_bit &&
             (bit_cnt_q == 3'd7) && (byte_cnt_q == '0)) begin
            pid_q <= shift_d;
         end
         if ((state_q == ST_EOP) && eop_ok) begin
            crc_ok_q <= !((pid_q == PID_DATA0) || (pid_q == PID_DATA1)) ||
                        (crc_val == CRC16_RESIDUAL);
         end
      end
   end

   assign crcOk = crc_ok_q;
`else
   assign crcOk = 1'b1;
`endif

endmodule

// File: tb/tb_usb_nrzi_rx.sv
// Bench for usb_nrzi_rx: a bit-level NRZI/stuffing transmitter drives the line, a monitor
// collects received bytes and packet events, and checks compare against packet-level expectations.
module tb_usb_nrzi_rx;

   localparam logic [1:0] SYM_J   = 2'b10;
   localparam logic [1:0] SYM_K   = 2'b01;
   localparam logic [1:0] SYM_SE0 = 2'b00;

   logic       useClk = 1'b0;
   logic       resetN;
   logic       bitEn;
   logic       dp;
   logic       dm;
   logic [7:0] rxData;
   logic       rxValid;
   logic       rxActive;
   logic       packetDone;
   logic       rxError;
   logic       busReset;
   logic       crcOk;

   usb_nrzi_rx dut (
      .useClk     (useClk),
      .resetN     (resetN),
      .bitEn      (bitEn),
      .dp         (dp),
      .dm         (dm),
      .rxData     (rxData),
      .rxValid    (rxValid),
      .rxActive   (rxActive),
      .packetDone (packetDone),
      .rxError    (rxError),
      .busReset   (busReset),
      .crcOk      (crcOk)
   );

   // ---------------- clock / watchdog ----------------
   always #5 useClk = ~useClk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached before the summary");
      $fatal(1, "timeout");
   end

   // ---------------- scoreboard state ----------------
   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   logic [7:0] pkt_q[$];
   int         done_cnt = 0;
   bit         bus_seen = 1'b0;
   bit         overlap_seen = 1'b0;
   logic       crc_at_done = 1'b1;
   logic [1:0] level = SYM_J;
   int         ones = 0;

   always @(negedge useClk) begin
      if (rxValid) got_q.push_back(rxData);
      if (packetDone) begin
         done_cnt++;
         crc_at_done = crcOk;
      end
      if (busReset) bus_seen = 1'b1;
      if (rxValid && packetDone) overlap_seen = 1'b1;
   end

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      got_q.delete();
      exp_q.delete();
      done_cnt    = 0;
      bus_seen    = 1'b0;
      crc_at_done = 1'b1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_sym(input logic [1:0] s);
      @(negedge useClk);
      @(negedge useClk);
      dp    = s[1];
      dm    = s[0];
      bitEn = 1'b1;
      @(negedge useClk);
      bitEn = 1'b0;
   endtask

   task automatic send_bit(input logic b);
      if (!b) level = (level == SYM_J) ? SYM_K : SYM_J;
      drive_sym(level);
   endtask

   task automatic send_data_bit(input logic b);
      send_bit(b);
      if (b) ones++;
      else ones = 0;
      if (ones == 6) begin
         send_bit(1'b0);
         ones = 0;
      end
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) send_data_bit(v[i]);
   endtask

   task automatic send_sync();
      for (int i = 0; i < 7; i++) send_bit(1'b0);
      send_bit(1'b1);
      ones = 0;
   endtask

   task automatic send_eop(input int n);
      for (int i = 0; i < n; i++) drive_sym(SYM_SE0);
      level = SYM_J;
      drive_sym(SYM_J);
   endtask

   task automatic idle(input int n);
      level = SYM_J;
      for (int i = 0; i < n; i++) drive_sym(SYM_J);
   endtask

   task automatic send_packet(input int partial, input logic [7:0] pval, input int se0);
      idle(2);
      send_sync();
      foreach (pkt_q[i]) send_byte(pkt_q[i]);
      for (int i = 0; i < partial; i++) send_data_bit(pval[i]);
      send_eop(se0);
      idle(3);
   endtask

   task automatic check_packet(input string name, input int exp_done, input bit exp_err,
                               input bit exp_bus);
      check_val($sformatf("%s byte count", name), got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check_val($sformatf("%s byte %0d", name, i), got_q[i], exp_q[i]);
      check_val($sformatf("%s packetDone count", name), done_cnt, exp_done);
      check_val($sformatf("%s rxError", name), rxError, exp_err);
      check_val($sformatf("%s busReset seen", name), bus_seen, exp_bus);
      check_val($sformatf("%s rxActive after", name), rxActive, 1'b0);
      clear_mon();
   endtask

`ifdef USB_RX_CRC16_EN
   function automatic logic [15:0] crc_model();
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      for (int i = 1; i < pkt_q.size(); i++) begin
         for (int b = 0; b < 8; b++) begin
            fb = c[15] ^ pkt_q[i][b];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
         end
      end
      return c;
   endfunction
`endif

   typedef struct {
      logic [31:0] data;
      int          nbytes;
      int          partial;
      logic [7:0]  pval;
      int          se0;
      int          exp_nvalid;
      int          exp_done;
      bit          exp_err;
      bit          exp_bus;
   } vec_t;

   // ---------------- main sequence ----------------
   initial begin : main
      vec_t       vecs[7];
      logic [7:0] rb;
      int         n;
      int         partial;
      int         se0;
      logic [7:0] pval;
      bit         exp_done_b;

      vecs[0] = '{32'h000000D2, 1, 0, 8'h00, 2, 1, 1, 1'b0, 1'b0};
      vecs[1] = '{32'h00FFFFC3, 3, 0, 8'h00, 2, 3, 1, 1'b0, 1'b0};
      vecs[2] = '{32'h00005AA5, 2, 3, 8'h05, 2, 2, 1, 1'b1, 1'b0};
      vecs[3] = '{32'h0000004B, 1, 0, 8'h00, 1, 1, 1, 1'b0, 1'b0};
      vecs[4] = '{32'h00000069, 1, 0, 8'h00, 3, 1, 1, 1'b0, 1'b0};
      vecs[5] = '{32'h00007FE1, 2, 0, 8'h00, 5, 2, 0, 1'b1, 1'b1};
      vecs[6] = '{32'hFE800201, 4, 7, 8'h7F, 2, 4, 1, 1'b1, 1'b0};

      resetN = 1'b0;
      bitEn  = 1'b0;
      dp     = 1'b1;
      dm     = 1'b0;
      repeat (3) @(negedge useClk);
      check_val("reset rxData", rxData, 8'h00);
      check_val("reset rxValid", rxValid, 1'b0);
      check_val("reset rxActive", rxActive, 1'b0);
      check_val("reset packetDone", packetDone, 1'b0);
      check_val("reset rxError", rxError, 1'b0);
      check_val("reset busReset", busReset, 1'b0);
      check_val("reset crcOk", crcOk, 1'b1);
      resetN = 1'b1;
      clear_mon();

      // ACK PID with exact rxValid / packetDone timing
      idle(2);
      send_sync();
      check_val("ack rxActive after sync", rxActive, 1'b1);
      rb = 8'hD2;
      for (int i = 0; i < 7; i++) send_data_bit(rb[i]);
      check_val("ack rxValid before 8th bit", rxValid, 1'b0);
      send_data_bit(rb[7]);
      check_val("ack rxValid on 8th bit", rxValid, 1'b1);
      check_val("ack rxData on 8th bit", rxData, 8'hD2);
      drive_sym(SYM_SE0);
      drive_sym(SYM_SE0);
      check_val("ack packetDone before J", packetDone, 1'b0);
      level = SYM_J;
      drive_sym(SYM_J);
      check_val("ack packetDone on J", packetDone, 1'b1);
      idle(3);
      exp_q.push_back(8'hD2);
      check_packet("ack", 1, 1'b0, 1'b0);

      // table-driven packets
      for (int v = 0; v < 7; v++) begin
         pkt_q.delete();
         for (int b = 0; b < vecs[v].nbytes; b++) pkt_q.push_back(vecs[v].data[8*b +: 8]);
         send_packet(vecs[v].partial, vecs[v].pval, vecs[v].se0);
         for (int b = 0; b < vecs[v].exp_nvalid; b++) exp_q.push_back(vecs[v].data[8*b +: 8]);
         check_packet($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_bus);
      end

      // seven consecutive ones, then error clears at next SYNC
      idle(2);
      send_sync();
      send_byte(8'hC3);
      for (int i = 0; i < 7; i++) send_bit(1'b1);
      send_byte(8'h55);
      send_eop(2);
      idle(3);
      exp_q.push_back(8'hC3);
      check_packet("stuff error", 1, 1'b1, 1'b0);
      idle(2);
      send_sync();
      check_val("rxError cleared at sync", rxError, 1'b0);
      check_val("rxActive at sync", rxActive, 1'b1);
      send_byte(8'hD2);
      send_eop(2);
      idle(3);
      exp_q.push_back(8'hD2);
      check_packet("after stuff error", 1, 1'b0, 1'b0);

      // K after SE0 ends the packet with an error and no packetDone
      idle(2);
      send_sync();
      send_byte(8'h2D);
      drive_sym(SYM_SE0);
      level = SYM_K;
      drive_sym(SYM_K);
      idle(3);
      exp_q.push_back(8'h2D);
      check_packet("K after SE0", 0, 1'b1, 1'b0);

      // short SYNC is rejected
      idle(2);
      drive_sym(SYM_K);
      drive_sym(SYM_J);
      drive_sym(SYM_K);
      drive_sym(SYM_K);
      idle(3);
      check_val("short sync rxActive", rxActive, 1'b0);
      check_val("short sync bytes", got_q.size(), 0);
      clear_mon();

      // bus reset from idle: busReset rises on the 4th SE0 bit, falls on J
      idle(2);
      for (int i = 0; i < 3; i++) drive_sym(SYM_SE0);
      check_val("busReset after 3 SE0", busReset, 1'b0);
      drive_sym(SYM_SE0);
      check_val("busReset after 4 SE0", busReset, 1'b1);
      drive_sym(SYM_SE0);
      check_val("busReset after 5 SE0", busReset, 1'b1);
      level = SYM_J;
      drive_sym(SYM_J);
      check_val("busReset after J", busReset, 1'b0);
      check_val("idle bus reset packetDone", done_cnt, 0);
      clear_mon();

      // reset during the second byte
      idle(2);
      send_sync();
      send_byte(8'hC3);
      rb = 8'hA5;
      for (int i = 0; i < 4; i++) send_data_bit(rb[i]);
      @(negedge useClk);
      resetN = 1'b0;
      #1;
      check_val("midreset rxData", rxData, 8'h00);
      check_val("midreset rxActive", rxActive, 1'b0);
      check_val("midreset rxError", rxError, 1'b0);
      check_val("midreset crcOk", crcOk, 1'b1);
      clear_mon();
      repeat (3) @(negedge useClk);
      resetN = 1'b1;
      check_val("midreset packetDone", done_cnt, 0);
      ones = 0;
      pkt_q = '{8'h4B, 8'h11, 8'h22};
      send_packet(0, 8'h00, 2);
      exp_q = pkt_q;
      check_packet("after reset", 1, 1'b0, 1'b0);

      // byte-count boundary: exactly MAX_BYTES is fine, one more is an overflow
      pkt_q.delete();
      for (int i = 0; i < 67; i++) pkt_q.push_back(8'($urandom));
      send_packet(0, 8'h00, 2);
      exp_q = pkt_q;
      check_packet("67 bytes", 1, 1'b0, 1'b0);
      pkt_q.delete();
      for (int i = 0; i < 68; i++) pkt_q.push_back(8'($urandom));
      send_packet(0, 8'h00, 2);
      for (int i = 0; i < 67; i++) exp_q.push_back(pkt_q[i]);
      check_packet("68 bytes", 1, 1'b1, 1'b0);

`ifdef USB_RX_CRC16_EN
      pkt_q = '{8'hC3, 8'h00, 8'h00};
      send_packet(0, 8'h00, 2);
      check_val("crc DATA0 empty", crc_at_done, 1'b1);
      clear_mon();
      pkt_q = '{8'hC3, 8'h00, 8'h01};
      send_packet(0, 8'h00, 2);
      check_val("crc DATA0 corrupt", crc_at_done, 1'b0);
      clear_mon();
      pkt_q = '{8'hD2};
      send_packet(0, 8'h00, 2);
      check_val("crc non-data pid", crc_at_done, 1'b1);
      clear_mon();
`endif

      // randomized packets against the packet-level model
      for (int r = 0; r < 20; r++) begin
         pkt_q.delete();
         n = $urandom_range(1, 8);
         for (int i = 0; i < n; i++)
            pkt_q.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
         if ($urandom_range(0, 2) == 0) pkt_q[0] = 8'hC3;
         partial = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 7));
         pval    = 8'($urandom);
         se0     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 6))
                                               : int'($urandom_range(1, 3));
         send_packet(partial, pval, se0);
         exp_done_b = (se0 <= 3);
`ifdef USB_RX_CRC16_EN
         if (exp_done_b && partial == 0)
            check_val($sformatf("rand%0d crcOk", r), crc_at_done,
                      ((pkt_q[0] == 8'hC3) || (pkt_q[0] == 8'h4B)) ? (crc_model() == 16'h800D) : 1'b1);
`endif
         exp_q = pkt_q;
         check_packet($sformatf("rand%0d", r), exp_done_b ? 1 : 0,
                      (partial != 0) || !exp_done_b, !exp_done_b);
      end

      check_val("rxValid never with packetDone", overlap_seen, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
